// File: rtl/pipelined_rc_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_rc_adder                                           |
// | Description : Pipelined ripple-carry adder/subtractor. Operands are cut    |
// |               into STAGES slices of WIDTH/STAGES bits; each slice is added |
// |               in its own stage with the carry registered between stages.   |
// |               Valid/ready handshake with a global stall for backpressure.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_rc_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  // Whole pipeline moves as one; a stall freezes every stage register.
  logic             adv;
  logic [WIDTH-1:0] b_x;
  logic [STAGES-1:0] vld_q;
  logic             last_vld_d;   // valid of the transaction entering the last stage
  logic [STAGES-1:0] cy_w;        // registered carry out of each stage

  assign in_ready  = ~out_valid | out_ready;
  assign adv       = in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign cout      = cy_w[STAGES-1];

  // Subtraction is folded in up front so every stage sees a plain adder.
  assign b_x = sub ? ~b : b;

  // Valid shift chain; bubbles travel with the data, they are never squeezed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  if (STAGES == 1) begin : g_last_single
    assign last_vld_d = in_valid;
  end else begin : g_last_multi
    assign last_vld_d = vld_q[STAGES-2];
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    // Number of deskew registers between this slice's adder and the output.
    localparam int D = STAGES - 1 - j;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic             c_in;
    logic [SLICE:0]   add_d;

    if (j == 0) begin : g_noskew
      assign a_s  = a[SLICE-1:0];
      assign b_s  = b_x[SLICE-1:0];
      assign c_in = cin;
    end else begin : g_skew
      logic [SLICE-1:0] a_dly_q [j];
      logic [SLICE-1:0] b_dly_q [j];

      // Delay operand slice j by j stages so it meets the carry from stage j-1.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_dly_q[0] <= a[j*SLICE +: SLICE];
          b_dly_q[0] <= b_x[j*SLICE +: SLICE];
          for (int m = 1; m < j; m++) begin
            a_dly_q[m] <= a_dly_q[m-1];
            b_dly_q[m] <= b_dly_q[m-1];
          end
        end
      end

      assign a_s  = a_dly_q[j-1];
      assign b_s  = b_dly_q[j-1];
      assign c_in = cy_w[j-1];
    end

    assign add_d = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, c_in};

    if (D == 0) begin : g_out_direct
      logic [SLICE-1:0] res_q;
      logic             cy_q;
      logic             ovf_q;
      logic             msb_cin;

      // Carry into the MSB recovered from the MSB's own sum bit.
      assign msb_cin = a_s[SLICE-1] ^ b_s[SLICE-1] ^ add_d[SLICE-1];

      // Last stage: output register, only loaded by a valid result.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_q <= '0;
          cy_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (adv && last_vld_d) begin
          res_q <= add_d[SLICE-1:0];
          cy_q  <= add_d[SLICE];
          ovf_q <= msb_cin ^ add_d[SLICE];
        end
      end

      assign sum[j*SLICE +: SLICE] = res_q;
      assign cy_w[j]               = cy_q;
      assign ovf                   = ovf_q;
    end else begin : g_out_deskew
      logic [SLICE-1:0] pipe_q [D];
      logic [SLICE-1:0] res_q;
      logic             cy_q;

      // Stage register for this slice plus the deskew chain behind it.
      always_ff @(posedge clk) begin
        if (adv) begin
          cy_q      <= add_d[SLICE];
          pipe_q[0] <= add_d[SLICE-1:0];
          for (int m = 1; m < D; m++) begin
            pipe_q[m] <= pipe_q[m-1];
          end
        end
      end

      // Output register for this slice, aligned with the last stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_q <= '0;
        end else if (adv && last_vld_d) begin
          res_q <= pipe_q[D-1];
        end
      end

      assign sum[j*SLICE +: SLICE] = res_q;
      assign cy_w[j]               = cy_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rc_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipelined_rc_adder                                        |
// | Description : Self-checking bench for pipelined_rc_adder: arithmetic       |
// |               reference model with an in-order scoreboard queue.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipelined_rc_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int or_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random
  int bp_idx  = 0;

  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

  pipelined_rc_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full-width arithmetic, overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
    v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {v, t[W], t[W-1:0]};
  endfunction

  // Scoreboard: inputs change only just after posedge, so negedge values are what the next edge sees.
  initial begin
    logic         prev_stall;
    logic [W+1:0] prev_out;
    logic [W+1:0] front;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("hold_stable", {ovf, cout, sum}, prev_out);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            front = exp_q[0];
            chk("out_sum", sum, front[W-1:0]);
            chk("out_cout", cout, front[W]);
            chk("out_ovf", ovf, front[W+1]);
          end
        end
        prev_stall = out_valid & ~out_ready;
        prev_out   = {ovf, cout, sum};
        if (out_valid && out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      end
    end
  end

  // Downstream ready driver.
  initial begin
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1: begin out_ready = pat[bp_idx % 4]; bp_idx++; end
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // One isolated transaction with literal expected result and exact latency.
  task automatic send_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic s, input logic [W-1:0] es,
                            input logic ec, input logic eo);
    repeat (S + 1) @(posedge clk);
    #1;
    in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
    @(negedge clk);
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      @(negedge clk);
      chk({name, "_early"}, out_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, ovf, eo);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    logic took;
    int guard;
    logic [W+1:0] m;

    rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;

    // Pin the reference model against hand-computed values.
    m = model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    chk("model_add", m, {1'b0, 1'b0, 32'h0000_0100});
    m = model(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    chk("model_sub_ovf", m, {1'b1, 1'b1, 32'h7FFF_FFFF});

    // Reset with in_valid high.
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    send_check("add", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    send_check("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send_check("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_check("sub", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_check("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain("directed");

    // Backpressure: 8 back-to-back operand sets with ready pattern 1,0,0,1.
    @(posedge clk);
    #1;
    base = n_out;
    bp_idx = 0;
    or_mode = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
      guard = 0;
      do begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!took && guard < 50);
      if (!took) chk("bp_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    drain("bp");
    chk("bp_count", n_out - base, 8);
    or_mode = 0;

    // Random traffic with random backpressure, including corner operands.
    base = n_out;
    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h8000_0000;
        2: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      cin = $urandom_range(0, 1);
      sub = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    or_mode = 0;
    drain("random");

    // Reset with three transactions in flight.
    repeat (S + 1) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = n_out;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    repeat (S + 2) @(posedge clk);
    chk("midrst_none_emerged", n_out - base, 0);
    send_check("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
